dtc_pipe_eval: RTL and testbench
================================

Name: dtc_pipe_eval

Overview:
- Parametrised, pipelined, run-time programmable decision-tree classifier.
- Successor to the fixed combinational per-benchmark tree blocks: tree structure and leaf values live in a loadable node table instead of hard-coded muxes.
- Evaluates one full binary tree of depth DEPTH, one level per pipeline stage, with valid/ready streaming on input and output.
- Sits between the feature-vector source and the result collector; one instance replaces any generated tree of matching depth and widths.

Parameters:
- IN_W, 8, feature vector width (bits of inp).
- OUT_W, 8, leaf/result width (bits of outp).
- DEPTH, 4, tree depth; 2^DEPTH-1 internal nodes, 2^DEPTH leaves; legal range 1..8.
- SEL_W, $clog2(IN_W), width of a node's feature-bit selector.
- ADDR_W, DEPTH, width of the config address.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  feature vector valid.
- in_ready  out  1  block accepts inp this cycle.
- inp  in  IN_W  feature vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts outp.
- outp  out  OUT_W  class/leaf value.
- cfg_we  in  1  table write request.
- cfg_leaf  in  1  1 = leaf table, 0 = node table.
- cfg_addr  in  ADDR_W  entry index.
- cfg_data  in  max(SEL_W,OUT_W)  write data; node writes use the low SEL_W bits.
- cfg_ready  out  1  write accepted this cycle.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset: all stage valids 0, out_valid=0, outp=0, node table all 0 (every node tests inp[0]), leaf table all 0, cfg_ready=1 on the first cycle after reset.
- Node indexing (heap order):
  - Root is node 0.
  - Children of node n are 2n+1 (selected bit = 0) and 2n+2 (selected bit = 1).
  - A node with sel=s tests inp[s].
  - A sel value >= IN_W is read as bit 0.
- Leaf index: the path bits concatenated, root decision as MSB (DEPTH bits).
- Pipeline:
  - Stage k (k = 0..DEPTH-1) registers the sample, its valid bit and its node index after resolving level k.
  - Stage DEPTH registers outp = leaf[path].
  - Latency from input handshake to out_valid is DEPTH+1 cycles.
  - Throughput is 1 sample/cycle.
- Flow control:
  - The pipeline advances as a unit when adv = !out_valid || out_ready.
  - in_ready = adv && !cfg_we.
  - Bubbles travel through as valid=0.
  - While adv=0 all stages hold, and outp/out_valid stay stable.
- Ordering: strict FIFO order; no drop and no duplication under any out_ready pattern.
- Configuration:
  - cfg_ready = 1 only when every stage valid and out_valid are 0.
  - A write occurs when cfg_we && cfg_ready and lands at the clock edge.
  - cfg_we with cfg_ready=0 is ignored; the requester holds cfg_we until it sees cfg_ready.
  - cfg_we has priority over input: in_ready=0 in any cycle cfg_we=1.
  - A node address >= 2^DEPTH-1 is ignored; leaf addresses use all ADDR_W bits.
- Simultaneous events:
  - An input accepted in the same cycle as out_ready removes the old result and moves the new sample into stage 0.
  - rst overrides everything, including a cfg write in the same cycle.
- Reset mid-operation: in-flight samples are discarded; out_valid=0 the next cycle; the tables revert to 0.

Optional Feature:
- Macro: DTC_HIT_CNT_EN.
- When defined:
  - Adds output port hit_cnt (16 bits) and input port cnt_clr (1 bit).
  - hit_cnt counts output handshakes (out_valid && out_ready) and saturates at 16'hFFFF.
  - cnt_clr synchronously zeroes the counter; if cnt_clr and a handshake occur in the same cycle, the counter becomes 0.
  - rst zeroes the counter.
- When undefined: neither port exists and there is no counter logic. Datapath timing is identical either way.

Test Plan:
- Post-reset default (DEPTH=4, IN_W=8): rst, then inp=0xFF with in_valid=1 for one cycle -> out_valid=1 exactly 5 cycles later, outp=0x00.
- Programmed path: all 15 nodes sel=2, leaf[i]=i*0x11 -> inp=0x04 gives outp=0xFF; inp=0xFB gives 0x00.
- Mixed selectors:
  - Setup: node0 sel=7, node2 sel=0, node6 sel=1, node14 sel=3, leaf[0xF]=0xA5, leaf[0xE]=0x3C.
  - inp=0x8B -> 0xA5.
  - inp=0x83 -> 0x3C.
- Backpressure: 8 back-to-back distinct samples while out_ready toggles 1,0,0,1,... -> 8 results in input order, outp stable while stalled, in_ready=0 whenever out_valid && !out_ready.
- Config guard: cfg_we issued while 2 samples are in flight -> cfg_ready=0 and no table change until drained; the write then lands the cycle cfg_ready=1, and in_ready=0 during that cycle.
- Reset mid-flight plus counter (DTC_HIT_CNT_EN):
  - After 3 handshakes, hit_cnt=3.
  - Assert rst with samples in flight -> out_valid=0 next cycle, hit_cnt=0, subsequent sample returns 0x00.

Source files
------------

// File: rtl/dtc_pipe_eval.sv
// Pipelined, run-time programmable decision-tree classifier: one tree level per stage, node/leaf tables loaded via cfg port.
// Define DTC_HIT_CNT_EN to add the saturating output-handshake counter (hit_cnt, cnt_clr).
module dtc_pipe_eval #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8,
  parameter int DEPTH  = 4,
  parameter int SEL_W  = $clog2(IN_W),
  parameter int ADDR_W = DEPTH,
  localparam int CFG_W = (SEL_W > OUT_W) ? SEL_W : OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   inp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  outp,
  input  logic              cfg_we,
  input  logic              cfg_leaf,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CFG_W-1:0]  cfg_data,
  output logic              cfg_ready
`ifdef DTC_HIT_CNT_EN
  ,
  output logic [15:0]       hit_cnt,
  input  logic              cnt_clr
`endif
);

  localparam int NODES  = (2 ** DEPTH) - 1;
  localparam int LEAVES = 2 ** DEPTH;
  localparam int IDX_W  = DEPTH + 1;

  logic [SEL_W-1:0] node_sel [NODES];
  logic [OUT_W-1:0] leaf_val [LEAVES];

  logic [IN_W-1:0]  st_data [DEPTH];
  logic [IDX_W-1:0] st_idx  [DEPTH];
  logic [DEPTH-1:0] st_vld;

  logic [IN_W-1:0]  lvl_data [DEPTH];
  logic [IDX_W-1:0] lvl_idx  [DEPTH];
  logic [IDX_W-1:0] nxt_idx  [DEPTH];
  logic [OUT_W-1:0] leaf_out;

  logic adv;
  logic in_fire;
  logic cfg_fire;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && !cfg_we;
  assign in_fire   = in_valid && in_ready;
  assign cfg_ready = !(|st_vld) && !out_valid;
  assign cfg_fire  = cfg_we && cfg_ready;

  assign lvl_data[0] = inp;
  assign lvl_idx[0]  = '0;

  for (genvar k = 1; k < DEPTH; k++) begin : g_src
    assign lvl_data[k] = st_data[k-1];
    assign lvl_idx[k]  = st_idx[k-1];
  end

  // Each level looks up its node's selector and steps to heap child 2n+1+bit.
  for (genvar k = 0; k < DEPTH; k++) begin : g_lvl
    logic [SEL_W-1:0] sel;
    logic             bit_v;

    always_comb begin
      sel = '0;
      for (int n = 0; n < NODES; n++) begin
        if (lvl_idx[k] == IDX_W'(n)) sel = node_sel[n];
      end
    end

    assign bit_v      = (int'(sel) < IN_W) ? lvl_data[k][sel] : lvl_data[k][0];
    assign nxt_idx[k] = (lvl_idx[k] << 1) + IDX_W'(1) + IDX_W'(bit_v);
  end

  // Final heap index minus NODES equals the path bits, root decision first.
  always_comb begin
    leaf_out = '0;
    for (int n = 0; n < LEAVES; n++) begin
      if (st_idx[DEPTH-1] == IDX_W'(NODES + n)) leaf_out = leaf_val[n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_vld    <= '0;
      out_valid <= 1'b0;
      outp      <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        st_data[k] <= '0;
        st_idx[k]  <= '0;
      end
      for (int n = 0; n < NODES; n++) node_sel[n] <= '0;
      for (int n = 0; n < LEAVES; n++) leaf_val[n] <= '0;
    end else begin
      if (adv) begin
        st_vld[0] <= in_fire;
        for (int k = 1; k < DEPTH; k++) st_vld[k] <= st_vld[k-1];
        for (int k = 0; k < DEPTH; k++) begin
          st_data[k] <= lvl_data[k];
          st_idx[k]  <= nxt_idx[k];
        end
        out_valid <= st_vld[DEPTH-1];
        outp      <= leaf_out;
      end
      // Writes only land with the pipe empty, so no in-flight sample sees a half-updated tree.
      if (cfg_fire) begin
        if (cfg_leaf) begin
          for (int n = 0; n < LEAVES; n++) begin
            if (cfg_addr == ADDR_W'(n)) leaf_val[n] <= cfg_data[OUT_W-1:0];
          end
        end else begin
          for (int n = 0; n < NODES; n++) begin
            if (cfg_addr == ADDR_W'(n)) node_sel[n] <= cfg_data[SEL_W-1:0];
          end
        end
      end
    end
  end

`ifdef DTC_HIT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      hit_cnt <= '0;
    end else if (out_valid && out_ready && (hit_cnt != 16'hFFFF)) begin
      hit_cnt <= hit_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dtc_pipe_eval.sv
// Scoreboard bench for dtc_pipe_eval (DEPTH=4, IN_W=8, OUT_W=8); counter checks compile in with DTC_HIT_CNT_EN.
module tb_dtc_pipe_eval;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] inp;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] outp;
  logic       cfg_we;
  logic       cfg_leaf;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_ready;
`ifdef DTC_HIT_CNT_EN
  logic [15:0] hit_cnt;
  logic        cnt_clr;
`endif

  always #5 clk = ~clk;

  dtc_pipe_eval dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp       (inp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outp      (outp),
    .cfg_we    (cfg_we),
    .cfg_leaf  (cfg_leaf),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready)
`ifdef DTC_HIT_CNT_EN
    ,
    .hit_cnt   (hit_cnt),
    .cnt_clr   (cnt_clr)
`endif
  );

  typedef struct packed {
    logic [7:0] exp;
    int         issue;
    logic       lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   out_mode = 1'b0;
  int   phase = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_outp = '0;
  int   waited;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready: constant 1, or the repeating 1,0,0 stall pattern
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (out_mode) begin
        out_ready = (phase % 3 == 0);
        phase++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake and watches stall behaviour
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        checkOutput("stall_out_valid", {15'd0, out_valid}, 16'd1);
        checkOutput("stall_outp", {8'd0, outp}, {8'd0, prev_outp});
      end
      if (out_valid && !out_ready) checkOutput("stall_in_ready", {15'd0, in_ready}, 16'd0);
      if (cfg_we) checkOutput("cfg_in_ready", {15'd0, in_ready}, 16'd0);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_result: got %0h, expected no output", outp);
        end else begin
          mon_e = sb_q.pop_front();
          checkOutput("result", {8'd0, outp}, {8'd0, mon_e.exp});
          if (mon_e.lat) checkOutput("latency", 16'(cyc - mon_e.issue), 16'd5);
        end
      end
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_outp  = outp;
  end

  // Called at posedge+1; holds in_valid until accepted, then queues the expected result
  task automatic applyStimulus(input logic [7:0] d, input logic [7:0] exp, input logic lat);
    int n = 0;
    in_valid = 1'b1;
    inp = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) fail_now("input_accept");
    else sb_q.push_back('{exp: exp, issue: cyc, lat: lat});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic apply_cfg(input logic lf, input logic [3:0] a, input logic [7:0] d, output int w);
    w = 0;
    cfg_we = 1'b1;
    cfg_leaf = lf;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    while (!cfg_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!cfg_ready) fail_now("cfg_accept");
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (sb_q.size() != 0 || out_valid) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  logic [7:0] bp_in  [8] = '{8'h8B, 8'h83, 8'h04, 8'h00, 8'h80, 8'h84, 8'h81, 8'h85};
  logic [7:0] bp_exp [8] = '{8'hA5, 8'h3C, 8'h77, 8'h00, 8'h88, 8'hBB, 8'hCC, 8'hDD};

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    inp = '0;
    cfg_we = 1'b0;
    cfg_leaf = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
`ifdef DTC_HIT_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("rst_outp", {8'd0, outp}, 16'd0);
    checkOutput("rst_cfg_ready", {15'd0, cfg_ready}, 16'd1);
    checkOutput("rst_in_ready", {15'd0, in_ready}, 16'd1);
`ifdef DTC_HIT_CNT_EN
    checkOutput("rst_hit_cnt", hit_cnt, 16'd0);
`endif
    @(posedge clk);
    #1;

    $display("[TB] default tables");
    applyStimulus(8'hFF, 8'h00, 1'b1);
    wait_idle();

    $display("[TB] programmed path: all nodes sel=2, leaf[i]=i*0x11");
    for (int n = 0; n < 15; n++) apply_cfg(1'b0, 4'(n), 8'd2, waited);
    for (int n = 0; n < 16; n++) apply_cfg(1'b1, 4'(n), 8'(n * 17), waited);
    applyStimulus(8'h04, 8'hFF, 1'b1);
    applyStimulus(8'hFB, 8'h00, 1'b1);
    wait_idle();

    $display("[TB] mixed selectors");
    apply_cfg(1'b0, 4'd0, 8'd7, waited);
    apply_cfg(1'b0, 4'd2, 8'd0, waited);
    apply_cfg(1'b0, 4'd6, 8'd1, waited);
    apply_cfg(1'b0, 4'd14, 8'd3, waited);
    apply_cfg(1'b1, 4'd15, 8'hA5, waited);
    apply_cfg(1'b1, 4'd14, 8'h3C, waited);
    applyStimulus(8'h8B, 8'hA5, 1'b1);
    applyStimulus(8'h83, 8'h3C, 1'b1);
    applyStimulus(8'h04, 8'h77, 1'b1);
    wait_idle();

    $display("[TB] backpressure");
    out_mode = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(bp_in[i], bp_exp[i], 1'b0);
    wait_idle();
    out_mode = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] config guard");
    applyStimulus(8'h00, 8'h00, 1'b1);
    applyStimulus(8'h00, 8'h00, 1'b1);
    apply_cfg(1'b1, 4'd0, 8'h5A, waited);
    checkOutput("cfg_held_off", {15'd0, (waited > 0)}, 16'd1);
    applyStimulus(8'h00, 8'h5A, 1'b1);
    wait_idle();

    $display("[TB] reset mid-flight");
`ifdef DTC_HIT_CNT_EN
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    applyStimulus(8'h8B, 8'hA5, 1'b1);
    applyStimulus(8'h83, 8'h3C, 1'b1);
    applyStimulus(8'h04, 8'h77, 1'b1);
    wait_idle();
    checkOutput("hit_cnt_3", hit_cnt, 16'd3);
`endif
    applyStimulus(8'h8B, 8'hA5, 1'b0);
    applyStimulus(8'h83, 8'h3C, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    checkOutput("midrst_out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("midrst_cfg_ready", {15'd0, cfg_ready}, 16'd1);
`ifdef DTC_HIT_CNT_EN
    checkOutput("midrst_hit_cnt", hit_cnt, 16'd0);
`endif
    @(posedge clk);
    #1;
    applyStimulus(8'h8B, 8'h00, 1'b1);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
